// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio frame buffer slice.
package audio_pkg;

    localparam int AUDIO_W = 12;
    localparam logic [AUDIO_W-1:0] SILENCE_DEF = 12'h800;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Unsigned channel complement: (2^w - 1) - s, done at up to 32 bits.
    function automatic logic [31:0] chan_complement(input logic [31:0] s, input int w);
        logic [31:0] fs;
        fs = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return fs - s;
    endfunction

endpackage

// File: rtl/audio_frame_buffer_if.sv
// Capture/playback side signals of the audio frame buffer.
interface audio_frame_buffer_if
    import audio_pkg::*;
#(
    parameter int DATA_W     = AUDIO_W,
    parameter int DEPTH_LOG2 = 3
);
    logic                  enable;
    logic [DATA_W-1:0]     sample_in;
    logic                  sample_valid;
    logic                  lrclk;
    logic                  clr_flags;
    logic [DATA_W-1:0]     audio_r;
    logic [DATA_W-1:0]     audio_l;
    logic [DEPTH_LOG2:0]   level;
    logic                  playing;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output enable, sample_in, sample_valid, lrclk, clr_flags,
        input  audio_r, audio_l, level, playing, overflow, underflow
    );

    modport slave (
        input  enable, sample_in, sample_valid, lrclk, clr_flags,
        output audio_r, audio_l, level, playing, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a synchronous flush; push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH      = 12,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic                pop_ok, push_ok;

    // Extra pointer bit keeps full (diff == DEPTH) distinct from empty.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == DEPTH_LVL);
    assign empty   = (level == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Pointer update; flush wins over any push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; the head is read before this edge so full push+pop is safe.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
    end
endmodule

// File: rtl/audio_frame_buffer.sv
// Elastic sample buffer between capture and the I2S transmitter: one pop
// per LRCLK frame once PREFILL samples are queued, sticky over/underflow.
module audio_frame_buffer
    import audio_pkg::*;
#(
    parameter int                DATA_W     = AUDIO_W,
    parameter int                DEPTH_LOG2 = 3,
    parameter int                PREFILL    = 4,
    parameter logic [DATA_W-1:0] SILENCE    = SILENCE_DEF,
    parameter bit                INVERT_L   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    audio_frame_buffer_if.slave  bus
);
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [LVL_W-1:0] PREFILL_LVL = LVL_W'(PREFILL);

    state_t             state_q, state_d;
    logic               lrclk_q, tick;
    logic               pop, under_evt, over_evt;
    logic               push_req, fifo_push, fifo_clr;
    logic               fifo_full, fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    logic [DATA_W-1:0]  head, head_inv;
    logic [DATA_W-1:0]  audio_r_q, audio_l_q;
    logic               overflow_q, underflow_q;

    assign tick      = lrclk_q & ~bus.lrclk;
    assign push_req  = bus.sample_valid & bus.enable & (state_q != IDLE);
    assign fifo_push = push_req & (~fifo_full | pop);
    assign over_evt  = push_req & fifo_full & ~pop;
    assign fifo_clr  = ~bus.enable | (state_q == IDLE);
    assign head_inv  = DATA_W'(chan_complement(32'(head), DATA_W));

    sync_fifo #(.WIDTH(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .pop   (pop),
        .wdata (bus.sample_in),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Frame clock history; resets high so release never looks like a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lrclk_q <= 1'b1;
        else     lrclk_q <= bus.lrclk;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, pop and underflow decisions.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        under_evt = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = FILL;
                FILL: if (tick && fifo_level >= PREFILL_LVL) begin
                    state_d = RUN;
                    pop     = 1'b1;
                end
                RUN: if (tick) begin
                    if (fifo_empty) begin
                        under_evt = 1'b1;
                        state_d   = FILL;
                    end else begin
                        pop = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Channel registers: silence when disabled, new pair on each pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            audio_r_q <= SILENCE;
            audio_l_q <= SILENCE;
        end else if (!bus.enable) begin
            audio_r_q <= SILENCE;
            audio_l_q <= SILENCE;
        end else if (pop) begin
            audio_r_q <= head;
            audio_l_q <= INVERT_L ? head_inv : head;
        end
    end

    // Sticky flags; a new event beats a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= over_evt  | (overflow_q  & ~bus.clr_flags);
            underflow_q <= under_evt | (underflow_q & ~bus.clr_flags);
        end
    end

    assign bus.audio_r   = audio_r_q;
    assign bus.audio_l   = audio_l_q;
    assign bus.level     = fifo_level;
    assign bus.playing   = (state_q == RUN);
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer with a queue-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_audio_frame_buffer;
    localparam logic [11:0] SIL = 12'h800;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    audio_frame_buffer_if #(.DATA_W(12), .DEPTH_LOG2(3)) bus ();

    audio_frame_buffer #(
        .DATA_W(12), .DEPTH_LOG2(3), .PREFILL(4), .SILENCE(12'h800), .INVERT_L(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a sample queue and a playback mode (0 idle, 1 fill, 2 run).
    int          q[$];
    int          m_mode = 0;
    bit          m_lr   = 1'b1;
    logic [11:0] e_r    = SIL;
    logic [11:0] e_l    = SIL;
    bit          e_ov   = 1'b0;
    bit          e_un   = 1'b0;
    bit          m_tk, m_ov, m_un;
    int          m_v;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_mode = 0; m_lr = 1'b1;
            e_r = SIL; e_l = SIL; e_ov = 1'b0; e_un = 1'b0;
        end else begin
            m_tk = m_lr && !bus.lrclk;
            m_lr = bus.lrclk;
            m_ov = 1'b0; m_un = 1'b0;
            if (!bus.enable) begin
                q.delete();
                m_mode = 0; e_r = SIL; e_l = SIL;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else begin
                if (m_tk && m_mode == 2 && q.size() == 0) begin
                    m_un = 1'b1; m_mode = 1;
                end else if (m_tk && (m_mode == 2 || q.size() >= 4)) begin
                    m_mode = 2;
                    m_v = q.pop_front();
                    e_r = 12'(m_v);
                    e_l = 12'(4095 - m_v);
                end
                if (bus.sample_valid) begin
                    if (q.size() < 8) q.push_back(int'(bus.sample_in));
                    else m_ov = 1'b1;
                end
            end
            e_ov = m_ov | (e_ov & !bus.clr_flags);
            e_un = m_un | (e_un & !bus.clr_flags);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_audio_r",   32'(bus.audio_r),   32'(e_r));
            chk("m_audio_l",   32'(bus.audio_l),   32'(e_l));
            chk("m_level",     32'(bus.level),     32'(q.size()));
            chk("m_playing",   32'(bus.playing),   32'(m_mode == 2));
            chk("m_overflow",  32'(bus.overflow),  32'(e_ov));
            chk("m_underflow", 32'(bus.underflow), 32'(e_un));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [11:0] v);
        bus.sample_in = v; bus.sample_valid = 1'b1;
        step(1);
        bus.sample_valid = 1'b0;
    endtask

    task automatic frame();
        bus.lrclk = 1'b0; step(2);
        bus.lrclk = 1'b1; step(2);
    endtask

    task automatic frame_chk(input string tag, input logic [11:0] er, input logic [11:0] el);
        bus.lrclk = 1'b0; step(1);
        chk({tag, "_r"},    32'(bus.audio_r), 32'(er));
        chk({tag, "_l"},    32'(bus.audio_l), 32'(el));
        chk({tag, "_play"}, 32'(bus.playing), 32'd1);
        step(1);
        bus.lrclk = 1'b1; step(2);
    endtask

    task automatic clr_pulse();
        bus.clr_flags = 1'b1; step(1);
        bus.clr_flags = 1'b0;
    endtask

    initial begin
        bus.enable = 1'b0; bus.sample_in = '0; bus.sample_valid = 1'b0;
        bus.lrclk = 1'b1; bus.clr_flags = 1'b0;
        step(2);
        chk("rst_audio_r", 32'(bus.audio_r), 32'h800);
        chk("rst_audio_l", 32'(bus.audio_l), 32'h800);
        chk("rst_level",   32'(bus.level),   32'd0);
        chk("rst_playing", 32'(bus.playing), 32'd0);
        rst = 1'b0; bus.enable = 1'b1;
        step(1);

        // 1: no data, three frames -> silence
        repeat (3) frame();
        chk("t1_audio_r", 32'(bus.audio_r), 32'h800);
        chk("t1_playing", 32'(bus.playing), 32'd0);
        chk("t1_flags",   32'({bus.overflow, bus.underflow}), 32'd0);

        // 2: prefill and play out
        push(12'h100); push(12'h200); push(12'h300); push(12'h400);
        chk("t2_level", 32'(bus.level), 32'd4);
        frame_chk("t2_f0", 12'h100, 12'hEFF);
        frame_chk("t2_f1", 12'h200, 12'hDFF);
        frame_chk("t2_f2", 12'h300, 12'hCFF);
        frame_chk("t2_f3", 12'h400, 12'hBFF);

        // 3: empty tick -> underflow, hold, refill resumes
        bus.lrclk = 1'b0; step(1);
        chk("t3_under",   32'(bus.underflow), 32'd1);
        chk("t3_hold_r",  32'(bus.audio_r),   32'h400);
        chk("t3_hold_l",  32'(bus.audio_l),   32'hBFF);
        chk("t3_playing", 32'(bus.playing),   32'd0);
        step(1); bus.lrclk = 1'b1; step(2);
        push(12'h123); push(12'h456); push(12'h789); push(12'hABC);
        frame_chk("t3_f0", 12'h123, 12'hEDC);
        frame_chk("t3_f1", 12'h456, 12'hBA9);
        frame_chk("t3_f2", 12'h789, 12'h876);
        frame_chk("t3_f3", 12'hABC, 12'h543);
        clr_pulse();
        chk("t3_clr", 32'({bus.overflow, bus.underflow}), 32'd0);

        // 4: ten pushes with no frames -> full, last two dropped
        for (int i = 1; i <= 10; i++) push(12'(i));
        chk("t4_level", 32'(bus.level),    32'd8);
        chk("t4_over",  32'(bus.overflow), 32'd1);
        frame_chk("t4_f0", 12'h001, 12'hFFE);
        clr_pulse();
        push(12'h00B);
        chk("t4_refull", 32'(bus.level), 32'd8);

        // 5: push on the tick while full -> both complete
        bus.lrclk = 1'b0; bus.sample_in = 12'h0C0; bus.sample_valid = 1'b1;
        step(1);
        bus.sample_valid = 1'b0;
        chk("t5_level", 32'(bus.level),    32'd8);
        chk("t5_over",  32'(bus.overflow), 32'd0);
        chk("t5_r",     32'(bus.audio_r),  32'h002);
        step(1); bus.lrclk = 1'b1; step(2);

        // 6: dropped push sets overflow, disable flushes but keeps flags
        push(12'h0DD);
        chk("t6_over", 32'(bus.overflow), 32'd1);
        bus.enable = 1'b0; step(1);
        bus.enable = 1'b1;
        chk("t6_dis_r",    32'(bus.audio_r),  32'h800);
        chk("t6_dis_l",    32'(bus.audio_l),  32'h800);
        chk("t6_dis_lvl",  32'(bus.level),    32'd0);
        chk("t6_dis_play", 32'(bus.playing),  32'd0);
        chk("t6_dis_over", 32'(bus.overflow), 32'd1);
        step(1);
        clr_pulse();
        chk("t6_clr", 32'({bus.overflow, bus.underflow}), 32'd0);
        push(12'h111); push(12'h222); push(12'h333); push(12'h444);
        frame_chk("t6_f0", 12'h111, 12'hEEE);

        // async reset in the middle of a tick cycle
        bus.lrclk = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_r",     32'(bus.audio_r),  32'h800);
        chk("t6_rst_l",     32'(bus.audio_l),  32'h800);
        chk("t6_rst_lvl",   32'(bus.level),    32'd0);
        chk("t6_rst_play",  32'(bus.playing),  32'd0);
        chk("t6_rst_flags", 32'({bus.overflow, bus.underflow}), 32'd0);
        step(1);
        rst = 1'b0; bus.lrclk = 1'b1;
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
